tie_inq_beat_serializer: RTL and testbench

- Consumer-side stage attached to a TIE input-queue pop interface (PopReq / data / Empty), such as the 96-bit INQ1 port fed by the inter-core queue.
- Pops one wide queue entry at a time and re-emits it as DATA_WIDTH/BEAT_WIDTH narrow beats on a valid/ready stream, for a narrow peripheral or trace port.
- Supports back-to-back entries with no bubble: the next pop occurs in the same cycle the last beat of the current entry is accepted.

---
 rtl/tie_inq_beat_serializer.sv | 91 +++++++++
 tb/tb_tie_inq_beat_serializer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tie_inq_beat_serializer.sv
// Pops wide entries from a TIE input queue and replays each one as a
// sequence of narrow beats on a valid/ready stream. The next entry is
// popped in the same cycle the last beat of the current entry is
// accepted, so back-to-back entries stream without a bubble.
//
// state   | meaning
// --------+-----------------------------------------------
// EMPTY   | hold register holds no entry, OutValid low
// SEND    | hold register holds an entry, beats being sent
module tie_inq_beat_serializer #(
    parameter int DATA_WIDTH = 96,
    parameter int BEAT_WIDTH = 32,
    parameter int MSB_FIRST  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    output logic                  TIE_INQ1_PopReq,
    input  logic [DATA_WIDTH-1:0] TIE_INQ1,
    input  logic                  TIE_INQ1_Empty,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [BEAT_WIDTH-1:0] OutData,
    output logic                  OutLast,
    output logic [CNT_WIDTH-1:0]  EntryCount
);

    localparam int NBEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [IDX_W-1:0]      beat_idx;
    logic [IDX_W-1:0]      beat_sel;
    logic                  hold_valid;
    logic                  beat_xfer;
    logic                  pop;

    assign hold_valid = (state == ST_SEND);
    assign OutValid   = hold_valid;
    assign OutLast    = hold_valid && (beat_idx == LAST_IDX);
    assign beat_xfer  = OutValid && OutReady;

    // A pop is only legal when the hold register is free now or is being
    // freed by the acceptance of its final beat this very cycle.
    assign pop = !Reset && !TIE_INQ1_Empty && (!hold_valid || (beat_xfer && OutLast));
    assign TIE_INQ1_PopReq = pop;

    // Map the beat counter onto the physical slice, honouring beat order.
    always_comb begin
        beat_sel = (MSB_FIRST != 0) ? (LAST_IDX - beat_idx) : beat_idx;
        OutData  = '0;
        for (int i = 0; i < NBEATS; i++) begin
            if (beat_sel == IDX_W'(i)) begin
                OutData = hold_reg[i*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    // Entry capture, beat stepping and entry counting.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= ST_EMPTY;
            hold_reg   <= '0;
            beat_idx   <= '0;
            EntryCount <= '0;
        end else begin
            if (pop) begin
                // Covers both EMPTY->SEND and the gapless SEND->SEND refill.
                state      <= ST_SEND;
                hold_reg   <= TIE_INQ1;
                beat_idx   <= '0;
                EntryCount <= EntryCount + CNT_WIDTH'(1);
            end else if (state == ST_SEND && beat_xfer) begin
                if (beat_idx == LAST_IDX) begin
                    state    <= ST_EMPTY;
                    beat_idx <= '0;
                end else begin
                    beat_idx <= beat_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tie_inq_beat_serializer.sv
// Scoreboard bench: two serializer instances (LSB-first with 16-bit count,
// MSB-first with 4-bit count) share one modelled input queue. Stimulus
// pushes entries and their expected beats; a negedge monitor compares.
module tb_tie_inq_beat_serializer;

    localparam int DW = 96;
    localparam int BW = 32;
    localparam int NB = DW / BW;

    typedef struct {
        logic [BW-1:0] d;
        logic          l;
    } beat_t;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic [DW-1:0] TIE_INQ1 = '0;
    logic          TIE_INQ1_Empty = 1'b1;
    logic          OutReady = 1'b0;

    logic          PopReq_a, OutValid_a, OutLast_a;
    logic [BW-1:0] OutData_a;
    logic [15:0]   EntryCount_a;
    logic          PopReq_b, OutValid_b, OutLast_b;
    logic [BW-1:0] OutData_b;
    logic [3:0]    EntryCount_b;

    logic [DW-1:0] fifo[$];
    beat_t         exp_a[$];
    beat_t         exp_b[$];
    int            errors = 0;
    int            checks = 0;
    int            exp_cnt = 0;
    int            acc_a = 0;
    int            pop_count = 0;
    logic          pop_pending = 1'b0;

    tie_inq_beat_serializer #(.DATA_WIDTH(DW), .BEAT_WIDTH(BW), .MSB_FIRST(0), .CNT_WIDTH(16)) dut_a (
        .CLK(CLK), .Reset(Reset), .TIE_INQ1_PopReq(PopReq_a), .TIE_INQ1(TIE_INQ1),
        .TIE_INQ1_Empty(TIE_INQ1_Empty), .OutValid(OutValid_a), .OutReady(OutReady),
        .OutData(OutData_a), .OutLast(OutLast_a), .EntryCount(EntryCount_a));

    tie_inq_beat_serializer #(.DATA_WIDTH(DW), .BEAT_WIDTH(BW), .MSB_FIRST(1), .CNT_WIDTH(4)) dut_b (
        .CLK(CLK), .Reset(Reset), .TIE_INQ1_PopReq(PopReq_b), .TIE_INQ1(TIE_INQ1),
        .TIE_INQ1_Empty(TIE_INQ1_Empty), .OutValid(OutValid_b), .OutReady(OutReady),
        .OutData(OutData_b), .OutLast(OutLast_b), .EntryCount(EntryCount_b));

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic refresh();
        TIE_INQ1_Empty = (fifo.size() == 0);
        TIE_INQ1 = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    task automatic push_entry(input logic [DW-1:0] d);
        fifo.push_back(d);
        for (int i = 0; i < NB; i++) begin
            exp_a.push_back('{d[i*BW +: BW], (i == NB-1)});
            exp_b.push_back('{d[(NB-1-i)*BW +: BW], (i == NB-1)});
        end
        exp_cnt++;
        refresh();
    endtask

    task automatic flush_model();
        fifo.delete();
        exp_a.delete();
        exp_b.delete();
        exp_cnt = 0;
        refresh();
    endtask

    // Assumes the caller sits at posedge+2.
    task automatic reset_dut();
        OutReady = 1'b0;
        Reset = 1'b1;
        flush_model();
        repeat (2) @(posedge CLK);
        #2 Reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge CLK); #2;
            if (fifo.size() == 0 && exp_a.size() == 0 && exp_b.size() == 0 && !OutValid_a && !OutValid_b)
                done = 1;
        end
        chk("drain_done", DW'(done), DW'(1));
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !OutValid_a; i++) begin
            @(posedge CLK); #2;
        end
        chk("first_valid", DW'(OutValid_a), DW'(1));
    endtask

    // Queue model: consume the head one step after the edge that popped it.
    always @(posedge CLK) begin
        #1;
        if (pop_pending) begin
            if (fifo.size() != 0) fifo.delete(0);
            pop_pending = 1'b0;
        end
        refresh();
    end

    // Monitor: beat scoreboard and pop-legality checks on the quiet edge.
    always @(negedge CLK) begin
        if (!Reset) begin
            if (OutValid_a) begin
                if (exp_a.size() == 0) chk("a_unexpected_beat", DW'(OutData_a), '0);
                else begin
                    chk("a_data", DW'(OutData_a), DW'(exp_a[0].d));
                    chk("a_last", DW'(OutLast_a), DW'(exp_a[0].l));
                    if (OutReady) begin
                        exp_a.delete(0);
                        acc_a++;
                    end
                end
            end
            if (OutValid_b) begin
                if (exp_b.size() == 0) chk("b_unexpected_beat", DW'(OutData_b), '0);
                else begin
                    chk("b_data", DW'(OutData_b), DW'(exp_b[0].d));
                    chk("b_last", DW'(OutLast_b), DW'(exp_b[0].l));
                    if (OutReady) exp_b.delete(0);
                end
            end
            chk("a_pop_legal", DW'(PopReq_a && (TIE_INQ1_Empty ||
                (OutValid_a && !(OutReady && OutLast_a)))), '0);
            chk("b_pop_legal", DW'(PopReq_b && (TIE_INQ1_Empty ||
                (OutValid_b && !(OutReady && OutLast_b)))), '0);
        end else begin
            chk("pop_in_reset", DW'(PopReq_a | PopReq_b), '0);
        end
        pop_pending = PopReq_a && !TIE_INQ1_Empty;
        if (pop_pending) pop_count++;
    end

    logic [DW-1:0] e;
    int            base;
    int            p0;
    logic          rdy_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // Reset values.
        @(posedge CLK); #2;
        @(negedge CLK);
        chk("rst_valid", DW'(OutValid_a), '0);
        chk("rst_last", DW'(OutLast_a), '0);
        chk("rst_data", DW'(OutData_a), '0);
        chk("rst_cnt_a", DW'(EntryCount_a), '0);
        chk("rst_cnt_b", DW'(EntryCount_b), '0);
        chk("rst_pop", DW'(PopReq_a), '0);
        @(posedge CLK); #2;
        reset_dut();

        // Single entry, ready high.
        p0 = pop_count;
        OutReady = 1'b1;
        e = 96'h333333332222222211111111;
        push_entry(e);
        drain(20);
        chk("single_pops", DW'(pop_count - p0), DW'(1));
        chk("single_cnt_a", DW'(EntryCount_a), DW'(1));
        chk("single_cnt_b", DW'(EntryCount_b), DW'(1));

        // Three pre-loaded entries stream gaplessly; pops coincide with the last beats.
        reset_dut();
        push_entry(96'hA3A3A3A3_A2A2A2A2_A1A1A1A1);
        push_entry(96'hB3B3B3B3_B2B2B2B2_B1B1B1B1);
        push_entry(96'hC3C3C3C3_C2C2C2C2_C1C1C1C1);
        OutReady = 1'b1;
        wait_valid(10);
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK);
            chk("stream_valid", DW'(OutValid_a), DW'(1));
            chk("stream_pop", DW'(PopReq_a), DW'(k == 2 || k == 5));
            @(posedge CLK); #2;
        end
        @(negedge CLK);
        chk("stream_idle", DW'(OutValid_a), '0);
        chk("stream_pop_empty", DW'(PopReq_a), '0);
        chk("stream_cnt", DW'(EntryCount_a), DW'(3));
        @(posedge CLK); #2;

        // Backpressure pattern 1,0,0,1,0,1 with a second entry waiting.
        OutReady = 1'b0;
        push_entry(96'hDEADBEEF_CAFEF00D_01234567);
        push_entry(96'h0BADC0DE_FEEDFACE_89ABCDEF);
        wait_valid(10);
        for (int k = 0; k < 6; k++) begin
            OutReady = rdy_pat[k];
            @(negedge CLK);
            chk("stall_pop", DW'(PopReq_a), DW'(k == 5));
            @(posedge CLK); #2;
        end
        OutReady = 1'b1;
        drain(20);
        chk("stall_cnt", DW'(EntryCount_a), DW'(5));

        // Reset after beat 1: rest of the entry is dropped, next entry starts at beat 0.
        reset_dut();
        OutReady = 1'b1;
        base = acc_a;
        push_entry(96'h55555555_44444444_12345678);
        for (int i = 0; i < 10 && acc_a != base + 2; i++) begin
            @(posedge CLK); #2;
        end
        chk("mid_two_beats", DW'(acc_a - base), DW'(2));
        Reset = 1'b1;
        OutReady = 1'b0;
        flush_model();
        push_entry(96'h99999999_88888888_77777777);
        @(negedge CLK);
        chk("mid_pop_in_reset", DW'(PopReq_a), '0);
        @(posedge CLK); #2;
        Reset = 1'b0;
        @(negedge CLK);
        chk("mid_valid", DW'(OutValid_a), '0);
        chk("mid_last", DW'(OutLast_a), '0);
        chk("mid_cnt", DW'(EntryCount_a), '0);
        chk("mid_pop_after", DW'(PopReq_a), DW'(1));
        @(posedge CLK); #2;
        OutReady = 1'b1;
        drain(20);
        chk("mid_cnt_after", DW'(EntryCount_a), DW'(1));

        // Seventeen entries: the 4-bit counter wraps to 1.
        reset_dut();
        OutReady = 1'b1;
        for (int i = 0; i < 17; i++) begin
            e = {32'(i * 3 + 2), 32'(i * 3 + 1), 32'(i * 3)};
            push_entry(e);
        end
        drain(17 * NB + 20);
        chk("wrap_cnt_a", DW'(EntryCount_a), DW'(17));
        chk("wrap_cnt_b", DW'(EntryCount_b), DW'(1));

        // Empty held high: no pop requests.
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            chk("idle_pop", DW'(PopReq_a | PopReq_b), '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
